uart_tx_fifo: RTL and testbench

//  Parametrised successor to uart_tx: buffered UART transmitter with an internal FIFO, ready/valid input handshake,

---
 rtl/uart_tx_fifo.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
//   A FIFO_DEPTH-word FIFO with a ready/valid push port feeds a frame FSM.
//   Frame format is sampled at the moment a word is popped:
//     start bit, 5..DATA_W data bits (LSB first), optional odd/even parity,
//     then 0, 1 or 2 stop bits.
//   A break request holds the line low for at least one bit period, then
//   sends one mark bit. Everything runs on the oversampling clock.
// Ports:
//   i_clkx16, i_rst        clock (OVS x baud), synchronous active-high reset
//   i_exist_oddcheck/
//   i_exist_evencheck      parity select (odd wins)
//   i_stop_bits            0: none, 1: one, 2/3: two
//   i_bitnum               data bits per frame, clamped to 5..DATA_W
//   i_break                break request
//   i_data, i_data_valid   push port, accepted when o_ready=1
//   o_ready                FIFO not full
//   o_fifo_level           stored words
//   o_busy                 frame/break in progress or FIFO non-empty
//   o_tx                   serial line, idle high
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS        = 16
) (
    input  logic                        i_clkx16,
    input  logic                        i_rst,
    input  logic                        i_exist_oddcheck,
    input  logic                        i_exist_evencheck,
    input  logic [1:0]                  i_stop_bits,
    input  logic [3:0]                  i_bitnum,
    input  logic                        i_break,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_data_valid,
    output logic                        o_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_busy,
    output logic                        o_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(OVS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_level;

    state_t            r_state;
    logic [TW-1:0]     r_tick;
    logic [3:0]        r_bitcnt;
    logic [3:0]        r_bitnum;
    logic [DATA_W-1:0] r_shift;
    logic              r_par_en, r_par_bit;
    logic [1:0]        r_stop, r_stop_idx;
    logic              r_tx, r_busy;

    logic              w_push, w_pop, w_fifo_ne, w_last_tick, w_frame_end;
    logic [3:0]        w_bitnum;
    logic [1:0]        w_stop;
    logic              w_par_calc;
    logic [DATA_W-1:0] w_head;

    assign o_ready      = (r_level != (AW+1)'(FIFO_DEPTH));
    assign o_fifo_level = r_level;
    assign o_busy       = r_busy;
    assign o_tx         = r_tx;

    assign w_fifo_ne   = (r_level != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = i_data_valid && o_ready;
    assign w_last_tick = (r_tick == TW'(OVS-1));
    assign w_stop      = i_stop_bits[1] ? 2'd2 : {1'b0, i_stop_bits[0]};

    always_comb begin
        if (i_bitnum < 4'd5)                w_bitnum = 4'd5;
        else if (i_bitnum > 4'(DATA_W))     w_bitnum = 4'(DATA_W);
        else                                w_bitnum = i_bitnum;
    end

    // Odd parity is the inverted XOR, so seed the accumulator with the odd flag.
    always_comb begin
        w_par_calc = i_exist_oddcheck;
        for (int i = 0; i < DATA_W; i++)
            if (i < int'(w_bitnum)) w_par_calc = w_par_calc ^ w_head[i];
    end

    // Last bit period of a frame; a queued word chains straight into START.
    assign w_frame_end = w_last_tick && (
        (r_state == S_DATA && r_bitcnt == r_bitnum - 4'd1 && !r_par_en && r_stop == 2'd0) ||
        (r_state == S_PARITY && r_stop == 2'd0) ||
        (r_state == S_STOP && r_stop_idx == r_stop - 2'd1));

    assign w_pop = w_fifo_ne && !i_break && (r_state == S_IDLE || w_frame_end);

    always_ff @(posedge i_clkx16)
        if (w_push) r_mem[r_wr_ptr] <= i_data;

    always_ff @(posedge i_clkx16) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clkx16) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bitcnt   <= '0;
            r_bitnum   <= 4'd5;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop     <= '0;
            r_stop_idx <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            // Line value follows the state one clock later, from a flop.
            case (r_state)
                S_START:  r_tx <= 1'b0;
                S_DATA:   r_tx <= r_shift[0];
                S_PARITY: r_tx <= r_par_bit;
                S_BREAK:  r_tx <= 1'b0;
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != S_IDLE) || w_fifo_ne;
            r_tick <= w_last_tick ? '0 : r_tick + 1'b1;

            if (w_pop) begin
                r_state    <= S_START;
                r_tick     <= '0;
                r_shift    <= w_head;
                r_bitnum   <= w_bitnum;
                r_par_en   <= i_exist_oddcheck || i_exist_evencheck;
                r_par_bit  <= w_par_calc;
                r_stop     <= w_stop;
                r_bitcnt   <= '0;
                r_stop_idx <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tick <= '0;
                        if (i_break) r_state <= S_BREAK;
                    end
                    S_START:
                        if (w_last_tick) r_state <= S_DATA;
                    S_DATA:
                        if (w_last_tick) begin
                            r_shift  <= r_shift >> 1;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == r_bitnum - 4'd1) begin
                                if (r_par_en)            r_state <= S_PARITY;
                                else if (r_stop != 2'd0) r_state <= S_STOP;
                                else                     r_state <= S_IDLE;
                            end
                        end
                    S_PARITY:
                        if (w_last_tick) r_state <= (r_stop != 2'd0) ? S_STOP : S_IDLE;
                    S_STOP:
                        if (w_last_tick) begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                            if (r_stop_idx == r_stop - 2'd1) r_state <= S_IDLE;
                        end
                    S_BREAK:
                        // Tick saturates once the minimum low period has elapsed.
                        if (w_last_tick) begin
                            if (!i_break) r_state <= S_MARK;
                            else          r_tick  <= r_tick;
                        end
                    S_MARK:
                        if (w_last_tick) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo, compared
// every clock against a line-level model (queue of words, queue of per-clock
// line symbols).
module tb_uart_tx_fifo;
    localparam int DATA_W = 8, FIFO_DEPTH = 16, OVS = 16;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, odd, even, brk, valid;
    logic [1:0]        stopb;
    logic [3:0]        bitnum;
    logic [DATA_W-1:0] data;
    logic              rdy, busy, tx;
    logic [LW-1:0]     lvl;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS)) dut (
        .i_clkx16(clk), .i_rst(rst), .i_exist_oddcheck(odd), .i_exist_evencheck(even),
        .i_stop_bits(stopb), .i_bitnum(bitnum), .i_break(brk), .i_data(data),
        .i_data_valid(valid), .o_ready(rdy), .o_fifo_level(lvl), .o_busy(busy), .o_tx(tx)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];      // words held in the FIFO
    bit                line[$];    // remaining line symbols, one per clock
    bit                line_mark;  // current line content is the post-break mark
    bit                m_brk, m_active, cur;
    int                brk_cnt;
    bit                e_tx, e_busy;

    task automatic build_frame(input logic [DATA_W-1:0] w);
        int nb, ones, ns;
        bit sym[$];
        nb = (bitnum < 5) ? 5 : ((bitnum > DATA_W) ? DATA_W : int'(bitnum));
        ones = 0;
        sym.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            sym.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (odd)       sym.push_back((ones % 2) == 0);
        else if (even) sym.push_back((ones % 2) == 1);
        ns = (stopb == 2'd0) ? 0 : ((stopb == 2'd1) ? 1 : 2);
        for (int i = 0; i < ns; i++) sym.push_back(1'b1);
        foreach (sym[k]) for (int j = 0; j < OVS; j++) line.push_back(sym[k]);
        line_mark = 1'b0;
    endtask

    task automatic mdl_edge();
        int sz0;
        bit fin, do_pop;
        e_tx   = cur;
        sz0    = mq.size();
        e_busy = m_active || (sz0 != 0);
        if (rst) begin
            mq.delete(); line.delete();
            m_brk = 0; m_active = 0; cur = 1; line_mark = 0;
            e_tx = 1; e_busy = 0;
            return;
        end
        fin = 0; do_pop = 0;
        if (m_brk) begin
            brk_cnt++;
            if (brk_cnt >= OVS && !brk) begin
                m_brk = 0;
                for (int j = 0; j < OVS; j++) line.push_back(1'b1);
                line_mark = 1;
            end
        end else if (line.size() != 0) begin
            void'(line.pop_front());
            if (line.size() == 0) begin
                fin = !line_mark;
                line_mark = 0;
            end
        end else begin
            if (brk) begin m_brk = 1; brk_cnt = 0; end
            else if (sz0 != 0) do_pop = 1;
        end
        if (fin && !brk && sz0 != 0) do_pop = 1;
        if (do_pop) build_frame(mq.pop_front());
        if (valid && sz0 < FIFO_DEPTH) mq.push_back(data);
        m_active = m_brk || (line.size() != 0);
        cur = m_brk ? 1'b0 : ((line.size() != 0) ? line[0] : 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
        chk("tx", 32'(tx), 32'(e_tx));
        chk("level", 32'(lvl), 32'(mq.size()));
        chk("ready", 32'(rdy), 32'(mq.size() < FIFO_DEPTH));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        valid = 1'b1; data = w;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int c;
        for (c = 1; c <= limit; c++) begin
            step();
            if (!busy) break;
        end
        chk(tag, 32'(c <= limit), 32'd1);
    endtask

    task automatic fmt(input bit o, input bit e, input logic [1:0] s, input logic [3:0] n);
        odd = o; even = e; stopb = s; bitnum = n;
    endtask

    initial begin
        int c;
        bit saw_full;
        int brk_hold;
        m_brk = 0; m_active = 0; cur = 1; line_mark = 0; brk_cnt = 0;
        rst = 1; brk = 0; valid = 0; data = '0;
        fmt(0, 0, 2'd1, 4'd8);
        repeat (2) step();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_level", 32'(lvl), 32'd0);
        rst = 0;

        // 8O1 0x55: o_tx falls 2 clocks after push, 176-clock frame, then not busy
        fmt(1, 0, 2'd1, 4'd8);
        push(8'h55);
        for (c = 1; c <= 400; c++) begin
            step();
            if (!busy) break;
        end
        chk("t1_len", 32'(c), 32'd178);

        // 5E2 with upper bits set that must not appear
        fmt(0, 1, 2'd2, 4'd5);
        push(8'h13 | 8'hE0);
        wait_idle("t2_idle", 400);

        // three back-to-back 8N1 frames
        fmt(0, 0, 2'd1, 4'd8);
        push(8'hA1); push(8'h3C); push(8'hF0);
        wait_idle("t3_idle", 800);

        // overfill the FIFO
        saw_full = 0;
        valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data = 8'(i * 7 + 1);
            step();
            if (!rdy) saw_full = 1;
        end
        valid = 1'b0;
        chk("t4_full_seen", 32'(saw_full), 32'd1);
        wait_idle("t4_idle", 4000);

        // break asserted mid-frame
        push(8'h9B); push(8'h24);
        repeat (40) step();
        brk = 1'b1;
        repeat (5 * OVS) step();
        brk = 1'b0;
        wait_idle("t5_idle", 1000);

        // reset while transmitting with words queued
        fmt(1, 0, 2'd2, 4'd7);
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        repeat (40) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_level", 32'(lvl), 32'd0);
        chk("t6_tx", 32'(tx), 32'd1);
        push(8'hC3);
        wait_idle("t6_idle", 400);

        // randomized traffic, formats, breaks and rare resets
        brk_hold = 0;
        for (int k = 0; k < 15000; k++) begin
            valid = ($urandom_range(0, 3) == 0);
            data  = DATA_W'($urandom);
            if ($urandom_range(0, 150) == 0)
                fmt(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
            if (brk_hold > 0) brk_hold--;
            else if ($urandom_range(0, 2500) == 0) brk_hold = $urandom_range(1, 3 * OVS);
            brk = (brk_hold > 0);
            rst = ($urandom_range(0, 6000) == 0);
            step();
        end
        valid = 0; brk = 0; rst = 0;
        wait_idle("rand_idle", 6000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
